// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencing controller for one loadable up-counter.
// Loads a start value, lets the counter run to a terminal value, pulses
// done on expiry and optionally reloads for periodic operation.
// Optional feature: define COUNTER_CTRL_PRESCALE_EN to divide the count
// rate by presc+1; without it the counter advances every RUN cycle and
// the presc port is ignored.
module counter_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             reload,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] term_val,
    input  logic [7:0]       presc,
    input  logic [WIDTH-1:0] cnt_out,
    output logic             cnt_load,
    output logic             cnt_enab,
    output logic [WIDTH-1:0] cnt_in,
    output logic             busy,
    output logic             done,
    output logic [7:0]       expire_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] start_val_q, start_val_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             reload_q, reload_d;
    logic             done_q, done_d;
    logic [7:0]       expire_q, expire_d;
    logic             match;
    logic             tick;

`ifdef COUNTER_CTRL_PRESCALE_EN
    logic [7:0] presc_q, presc_d;
    logic [7:0] pcnt_q, pcnt_d;

    // Prescale divider: restarts at zero whenever RUN is (re)entered.
    always_comb begin
        presc_d = presc_q;
        if (state_q == IDLE && start) begin
            presc_d = presc;
        end
        tick   = (pcnt_q == presc_q);
        pcnt_d = 8'd0;
        if (state_q == RUN && !tick) begin
            pcnt_d = pcnt_q + 8'd1;
        end
    end

    // Prescale registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= 8'd0;
            pcnt_q  <= 8'd0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`else
    logic presc_unused;

    assign presc_unused = ^presc;
    assign tick         = 1'b1;
`endif

    assign match = (cnt_out == term_q);

    // Next-state logic: run sequencing, field latching and expiry bookkeeping.
    always_comb begin
        state_d     = state_q;
        start_val_d = start_val_q;
        term_d      = term_q;
        reload_d    = reload_q;
        expire_d    = expire_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_val_d = start_val;
                    term_d      = term_val;
                    reload_d    = reload;
                    expire_d    = 8'd0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                state_d = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (match) begin
                    done_d = 1'b1;
                    if (expire_q != 8'hFF) begin
                        expire_d = expire_q + 8'd1;
                    end
                    state_d = reload_q ? LOAD : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-field registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            start_val_q <= '0;
            term_q      <= '0;
            reload_q    <= 1'b0;
            done_q      <= 1'b0;
            expire_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            start_val_q <= start_val_d;
            term_q      <= term_d;
            reload_q    <= reload_d;
            done_q      <= done_d;
            expire_q    <= expire_d;
        end
    end

    // Counter pins decode from state; enable stops on the terminal value so
    // load and enable can never be active together.
    assign cnt_load   = (state_q == LOAD);
    assign cnt_enab   = (state_q == RUN) && tick && !match;
    assign cnt_in     = start_val_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign expire_cnt = expire_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Testbench for counter_ctrl: behavioural counter attached to the DUT,
// expiry events predicted from run parameters into a scoreboard queue and
// compared by an independent monitor whenever done pulses.
module tb_counter_ctrl;

`ifdef COUNTER_CTRL_PRESCALE_EN
    localparam int PS = 1;
`else
    localparam int PS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       reload = 1'b0;
    logic [4:0] start_val = '0;
    logic [4:0] term_val = '0;
    logic [7:0] presc = '0;
    logic [4:0] cnt_out;
    logic       cnt_load, cnt_enab, busy, done;
    logic [4:0] cnt_in;
    logic [7:0] expire_cnt;

    logic [4:0] cnt_m = '0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        int cyc;
        int ecnt;
        int term;
    } exp_t;
    exp_t sbq[$];

    counter_ctrl #(.WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .reload(reload),
        .start_val(start_val), .term_val(term_val), .presc(presc),
        .cnt_out(cnt_out), .cnt_load(cnt_load), .cnt_enab(cnt_enab),
        .cnt_in(cnt_in), .busy(busy), .done(done), .expire_cnt(expire_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Attached loadable up-counter (no reset of its own).
    always @(posedge clk) begin
        if (cnt_load) cnt_m <= cnt_in;
        else if (cnt_enab) cnt_m <= cnt_m + 5'd1;
    end
    assign cnt_out = cnt_m;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // Monitor: checks exclusivity every cycle and pops one prediction per done.
    always @(negedge clk) begin
        if (!rst) begin
            chk("load_enab_exclusive", int'(cnt_load & cnt_enab), 0);
            if (done) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done cycle=%0d actual=1 required=0", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("expire_cnt_at_done", int'(expire_cnt), e.ecnt);
                    chk("cnt_out_at_done", int'(cnt_m), e.term);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // One run: predicts every done from start/term/presc/stop timing.
    task automatic do_run(input logic [4:0] s, input logic [4:0] t, input logic rel,
                          input logic [7:0] p, input int stop_off);
        logic [4:0] d;
        int k, n, per, j, m, end_cyc, nexp, hold;
        exp_t e;
        d   = t - s;
        n   = int'(d);
        per = n * (PS != 0 ? int'(p) + 1 : 1);
        start = 1'b1; start_val = s; term_val = t; reload = rel; presc = p;
        k = cyc;
        j = (stop_off >= 0) ? k + stop_off : 32'h7fff_ffff;
        nexp = 0;
        m = k + 2 + per;
        if (rel) begin
            while (m < j) begin
                nexp++;
                e.cyc = m + 1; e.ecnt = sat(nexp); e.term = int'(t);
                sbq.push_back(e);
                m = m + per + 2;
            end
            end_cyc = j + 1;
        end else if (m < j) begin
            nexp = 1;
            e.cyc = m + 1; e.ecnt = 1; e.term = int'(t);
            sbq.push_back(e);
            end_cyc = m + 1;
        end else begin
            end_cyc = j + 1;
        end
        step();
        chk("load_pulse", int'(cnt_load), 1);
        chk("load_value", int'(cnt_in), int'(s));
        chk("enab_in_load", int'(cnt_enab), 0);
        while (cyc < end_cyc) begin
            chk("busy_in_run", int'(busy), 1);
            stop  = (cyc == j);
            start = ($urandom_range(0, 3) == 0);
            start_val = 5'($urandom); term_val = 5'($urandom);
            reload = 1'($urandom); presc = 8'($urandom);
            step();
        end
        start = 1'b0; stop = 1'b0;
        chk("busy_after_run", int'(busy), 0);
        chk("enab_after_run", int'(cnt_enab), 0);
        chk("load_after_run", int'(cnt_load), 0);
        hold = int'(cnt_m);
        step();
        step();
        chk("cnt_holds_idle", int'(cnt_m), hold);
        chk("expire_final", int'(expire_cnt), sat(nexp));
        chk("all_dones_seen", sbq.size(), 0);
    endtask

    initial begin
        exp_t e;
        int k, mode, lim;
        logic [4:0] rs, rt;
        logic [7:0] rp;
        logic rr;

        // Reset state.
        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_load", int'(cnt_load), 0);
        chk("rst_enab", int'(cnt_enab), 0);
        chk("rst_cnt_in", int'(cnt_in), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_expire", int'(expire_cnt), 0);
        rst = 1'b0;
        step();

        // Directed runs.
        do_run(5'h03, 5'h07, 1'b0, 8'd0, -1);      // one-shot, N=4
        do_run(5'h1E, 5'h01, 1'b0, 8'd0, -1);      // wrap through zero
        do_run(5'h02, 5'h04, 1'b1, 8'd0, 13);      // reload, three expiries then stop
        do_run(5'h00, 5'h14, 1'b0, 8'd0, 7);       // stop mid-run
        do_run(5'h01, 5'h04, 1'b0, 8'd0, 5);       // stop together with match
        do_run(5'h06, 5'h06, 1'b0, 8'd0, -1);      // immediate match
        do_run(5'h00, 5'h02, 1'b0, 8'd2, -1);      // prescaled when enabled
        do_run(5'h09, 5'h09, 1'b1, 8'd0, 522);     // expire_cnt saturation
        do_run(5'h04, 5'h08, 1'b1, 8'd1, 1);       // stop during LOAD

        // Randomized runs.
        for (int i = 0; i < 24; i++) begin
            rs = 5'($urandom); rt = 5'($urandom);
            rr = 1'($urandom);
            rp = 8'($urandom_range(0, 3));
            lim = int'(5'(rt - rs)) * (PS != 0 ? int'(rp) + 1 : 1);
            if (rr) mode = $urandom_range(1, 3 * (lim + 2) + 2);
            else if ($urandom_range(0, 1) == 0) mode = -1;
            else mode = $urandom_range(1, lim + 3);
            do_run(rs, rt, rr, rp, mode);
        end

        // Asynchronous reset in the middle of a periodic run.
        start = 1'b1; start_val = 5'h0A; term_val = 5'h0A; reload = 1'b1; presc = 8'd0;
        k = cyc;
        for (int i = 1; i <= 3; i++) begin
            e.cyc = k + 1 + 2 * i; e.ecnt = i; e.term = 10;
            sbq.push_back(e);
        end
        step();
        start = 1'b0;
        while (cyc < k + 8) step();
        chk("expire_before_reset", int'(expire_cnt), 3);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_load", int'(cnt_load), 0);
        chk("async_rst_enab", int'(cnt_enab), 0);
        chk("async_rst_cnt_in", int'(cnt_in), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_expire", int'(expire_cnt), 0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("dones_before_reset", sbq.size(), 0);
        chk("idle_after_reset", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencing controller for the loadable up-counter (`counter`, ports `load`/`enab`/`cnt_in`/`cnt_out`). It drives the counter's load and enable pins to run interval timing: load a start value, count to a terminal value, flag expiry, and optionally auto-reload for periodic operation. It sits between software-visible control registers and one `counter` instance, which it owns exclusively.

## Interface
- `WIDTH`, 5, counter width; must match the attached `counter` instance.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `stop`  in  1  abort a run; sampled in LOAD and RUN.
- `reload`  in  1  mode: 1 = periodic auto-reload, 0 = one-shot; latched on accepted `start`.
- `start_val`  in  WIDTH  value loaded into counter; latched on accepted `start`.
- `term_val`  in  WIDTH  terminal count; latched on accepted `start`.
- `presc`  in  8  prescale divider minus one; latched on accepted `start` (see Configuration).
- `cnt_out`  in  WIDTH  current counter value, from `counter`.
- `cnt_load`  out  1  to `counter.load`.
- `cnt_enab`  out  1  to `counter.enab`.
- `cnt_in`  out  WIDTH  to `counter.cnt_in`; equals latched start value.
- `busy`  out  1  high while state is not IDLE.
- `done`  out  1  one-cycle expiry pulse.
- `expire_cnt`  out  8  number of expiries since last accepted `start`; saturates at 255.

## Operation
- States: IDLE, LOAD, RUN.
- IDLE: `cnt_load`=0, `cnt_enab`=0. `start`=1 -> latch `start_val`/`term_val`/`reload`/`presc`, clear `expire_cnt`, go LOAD. `start` while not IDLE is ignored.
- LOAD (exactly one cycle): `cnt_load`=1, `cnt_enab`=0 -> RUN. `stop`=1 -> IDLE instead.
- RUN: match = (`cnt_out` == latched term). `cnt_enab` = tick & ~match. On match: `done` pulses next cycle, `expire_cnt` increments (saturating), next state LOAD if reload else IDLE. `stop`=1 -> IDLE, no `done`, takes priority over match.
- Counting is modulo 2^WIDTH: term below start wraps through 0. Increments to expiry N = (term - start) mod 2^WIDTH; start == term gives immediate match (N=0).
- `cnt_load`, `cnt_enab` decoded from state register plus match compare; `done`, `busy`, `expire_cnt` registered/state-decoded.
- Controller never asserts `cnt_load` and `cnt_enab` together.

## Timing
- Reset: state IDLE, `cnt_load`=0, `cnt_enab`=0, `cnt_in`=0, `busy`=0, `done`=0, `expire_cnt`=0, latched fields 0. Reset mid-run aborts immediately with no `done`.
- `start` sampled at edge k: LOAD in cycle k+1; RUN from k+2 with `cnt_out`=start.
- Without prescale, match in cycle k+2+N; `done` high in cycle k+3+N; in one-shot `busy` falls same cycle `done` rises.
- Reload period: N+2 cycles per expiry (one LOAD + N+1 RUN cycles).
- `stop` sampled at edge j: `busy`=0 and `cnt_enab`=0 from cycle j+1; counter holds its value.

## Configuration
- `COUNTER_CTRL_PRESCALE_EN` defined: tick asserts once every presc+1 RUN cycles (8-bit prescale counter cleared on each entry to RUN, tick on first RUN cycle being the (presc+1)th); expiry latency becomes k+3+N*(presc+1)-ish per prescale count: match cycle = k+2+N*(presc+1).
- Not defined: tick=1 every RUN cycle; `presc` port present but ignored; no prescale counter synthesized.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> all outputs 0 immediately, `busy`=0.
- One-shot, WIDTH=5, start=0x03, term=0x07, start at k -> `cnt_load`=1 with `cnt_in`=0x03 in k+1; `cnt_enab` high 4 cycles; `done` high only in k+7; `expire_cnt`=1; `busy` low from k+7.
- Wrap: start=0x1E, term=0x01 -> counter 0x1E,0x1F,0x00,0x01; `done` in k+6.
- Reload: start=0x02, term=0x04, reload=1 -> `done` every 4 cycles; `expire_cnt` 1,2,3; `start` pulses while busy ignored; stop ends with no further `done`.
- Stop mid-RUN at `cnt_out`=0x05 -> `busy`=0 next cycle, no `done`, `cnt_out` holds 0x05; simultaneous stop and match -> no `done`.
- With `COUNTER_CTRL_PRESCALE_EN`, presc=2, start=0x00, term=0x02 -> counter increments every 3 cycles; `done` in k+3+6=k+9.
